// File: rtl/vga_mon_pkg.sv
// Shared types and the per-pixel checksum step for the VGA frame monitor.
package vga_mon_pkg;

  localparam int unsigned CntWDefault = 12;

  typedef logic [CntWDefault-1:0] cnt_t;
  typedef logic [31:0]            crc_t;

  typedef enum logic [0:0] {StSearch, StMeasure} state_e;

  // Rotate left by one, then fold in the 24-bit RGB sample.
  function automatic crc_t crc_step(crc_t crc, logic [23:0] rgb);
    return {crc[30:0], crc[31]} ^ {8'h00, rgb};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync polarity normaliser with a pix_en-gated rising-edge detector on the asserted level.
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic pix_en,
  input  logic sync_raw,
  output logic rise
);

  logic sync_a;
  logic prev_q;

  assign sync_a = sync_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (clear) begin
      prev_q <= 1'b0;
    end else if (pix_en) begin
      prev_q <= sync_a;
    end
  end

  assign rise = pix_en & sync_a & ~prev_q;

endmodule

// File: rtl/vga_frame_monitor.sv
// Passive VGA bus sink: recovers frame geometry, a per-frame pixel checksum and a
// line-width consistency flag, publishing them once per frame.
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter bit          HS_ACTIVE_LOW = 1'b1,
  parameter bit          VS_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W         = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  input  logic [7:0]       vga_r,
  input  logic [7:0]       vga_g,
  input  logic [7:0]       vga_b,
  input  logic             clear,
  output logic             locked,
  output logic             frame_done,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [31:0]      frame_crc,
  output logic [15:0]      frame_count,
  output logic             width_err
);

  typedef logic [CNT_W-1:0] cnt_w_t;

  function automatic cnt_w_t sat_inc(cnt_w_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic        hs_rise, vs_rise;
  logic [23:0] rgb;
  state_e      state_q, state_d;
  logic        start, acc_en, line_close, frame_close, pix_acc, zero_acc;

  // Accumulators; first_w doubles as the "first non-empty line seen" flag.
  cnt_w_t line_cycles_q, line_act_q, h_total_acc_q, v_total_acc_q, v_active_acc_q, first_w_q;
  logic   err_acc_q;
  crc_t   crc_acc_q;

  // c_*: values after the line close; d_*: after zeroing and pixel accumulate.
  cnt_w_t c_lc, c_la, c_ht, c_vt, c_va, c_fw;
  logic   c_err;
  crc_t   c_crc;
  cnt_w_t d_lc, d_la, d_ht, d_vt, d_va, d_fw;
  logic   d_err;
  crc_t   d_crc;

  logic   locked_q, frame_done_q, width_err_q;
  cnt_w_t h_active_q, v_active_q, h_total_q, v_total_q;
  crc_t   frame_crc_q;
  logic [15:0] frame_count_q;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_sync_edge #(
    .ACTIVE_LOW(HS_ACTIVE_LOW)
  ) u_hs_edge (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .pix_en   (pix_en),
    .sync_raw (vga_hs),
    .rise     (hs_rise)
  );

  vga_sync_edge #(
    .ACTIVE_LOW(VS_ACTIVE_LOW)
  ) u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .pix_en   (pix_en),
    .sync_raw (vga_vs),
    .rise     (vs_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
    end else if (clear) begin
      state_q <= StSearch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch:  if (vs_rise) state_d = StMeasure;
      StMeasure: state_d = StMeasure;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    acc_en = 1'b0;
    unique case (state_q)
      StSearch:  start  = vs_rise;
      StMeasure: acc_en = pix_en;
    endcase
    line_close  = acc_en & (hs_rise | vs_rise);
    frame_close = acc_en & vs_rise;
    pix_acc     = start | acc_en;
    zero_acc    = start | frame_close;
  end

  always_comb begin
    c_lc  = line_cycles_q;
    c_la  = line_act_q;
    c_ht  = h_total_acc_q;
    c_vt  = v_total_acc_q;
    c_va  = v_active_acc_q;
    c_fw  = first_w_q;
    c_err = err_acc_q;
    c_crc = crc_acc_q;
    if (line_close) begin
      c_ht = line_cycles_q;
      if (hs_rise) c_vt = sat_inc(v_total_acc_q);
      if (line_act_q != '0) begin
        c_va = sat_inc(v_active_acc_q);
        if (first_w_q == '0) begin
          c_fw = line_act_q;
        end else if (line_act_q != first_w_q) begin
          c_err = 1'b1;
        end
      end
      c_lc = '0;
      c_la = '0;
    end
  end

  // The sample carrying an edge belongs to the new line/frame, so it lands after zeroing.
  always_comb begin
    d_lc  = c_lc;
    d_la  = c_la;
    d_ht  = c_ht;
    d_vt  = c_vt;
    d_va  = c_va;
    d_fw  = c_fw;
    d_err = c_err;
    d_crc = c_crc;
    if (zero_acc) begin
      d_lc  = '0;
      d_la  = '0;
      d_ht  = '0;
      d_vt  = '0;
      d_va  = '0;
      d_fw  = '0;
      d_err = 1'b0;
      d_crc = '0;
    end
    if (pix_acc) begin
      d_lc = sat_inc(d_lc);
      if (vga_blank_n) begin
        d_la  = sat_inc(d_la);
        d_crc = crc_step(d_crc, rgb);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cycles_q  <= '0;
      line_act_q     <= '0;
      h_total_acc_q  <= '0;
      v_total_acc_q  <= '0;
      v_active_acc_q <= '0;
      first_w_q      <= '0;
      err_acc_q      <= 1'b0;
      crc_acc_q      <= '0;
    end else if (clear) begin
      line_cycles_q  <= '0;
      line_act_q     <= '0;
      h_total_acc_q  <= '0;
      v_total_acc_q  <= '0;
      v_active_acc_q <= '0;
      first_w_q      <= '0;
      err_acc_q      <= 1'b0;
      crc_acc_q      <= '0;
    end else if (pix_acc) begin
      line_cycles_q  <= d_lc;
      line_act_q     <= d_la;
      h_total_acc_q  <= d_ht;
      v_total_acc_q  <= d_vt;
      v_active_acc_q <= d_va;
      first_w_q      <= d_fw;
      err_acc_q      <= d_err;
      crc_acc_q      <= d_crc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      frame_crc_q   <= '0;
      frame_count_q <= '0;
      width_err_q   <= 1'b0;
    end else if (clear) begin
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      frame_crc_q   <= '0;
      frame_count_q <= '0;
      width_err_q   <= 1'b0;
    end else begin
      frame_done_q <= frame_close;
      if (start) locked_q <= 1'b1;
      if (frame_close) begin
        h_active_q    <= c_fw;
        v_active_q    <= c_va;
        h_total_q     <= c_ht;
        v_total_q     <= c_vt;
        frame_crc_q   <= c_crc;
        width_err_q   <= c_err;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign h_active    = h_active_q;
  assign v_active    = v_active_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign frame_crc   = frame_crc_q;
  assign frame_count = frame_count_q;
  assign width_err   = width_err_q;

endmodule
